// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data load-store) arbiter in front of one
// single-port synchronous memory. One transfer in flight: IDLE -> ACCESS -> RESP.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // instruction requester
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  // data requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            stateReg, stateNext;
  logic              lastDReg;
  logic              latIsDReg;
  logic              latWeReg;
  logic [ADDR_W-1:0] latAddrReg;
  logic [DATA_W-1:0] latWdataReg;
  logic [DATA_W-1:0] iRdataReg;
  logic [DATA_W-1:0] dRdataReg;

  logic misaligned;
  logic accept;
  logic [DATA_W-1:0] dRespData;

  // Only data accesses are alignment-checked; fetches pass any address through.
  assign misaligned = latIsDReg && (latAddrReg[1:0] != 2'b00);
  assign accept     = i_gnt || d_gnt;
  assign dRespData  = misaligned ? '0 : mem_rdata;

  always_comb begin
    stateNext = stateReg;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (stateReg)
      IDLE: begin
        if (!reset) begin
          // Contention goes to D unless D won the previous accepted grant.
          d_gnt = d_req && (!i_req || !lastDReg);
          i_gnt = i_req && !d_gnt;
        end
        if (i_gnt || d_gnt) stateNext = ACCESS;
      end
      ACCESS: begin
        stateNext = RESP;
        if (!misaligned) begin
          mem_en    = 1'b1;
          mem_we    = latWeReg;
          mem_addr  = latAddrReg;
          mem_wdata = latWdataReg;
        end
      end
      RESP: begin
        stateNext = IDLE;
        if (!reset) begin
          i_done = !latIsDReg;
          d_done = latIsDReg;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign d_err   = d_done && misaligned;
  assign i_rdata = i_done ? mem_rdata : iRdataReg;
  assign d_rdata = d_done ? dRespData : dRdataReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= IDLE;
      lastDReg    <= 1'b0;
      latIsDReg   <= 1'b0;
      latWeReg    <= 1'b0;
      latAddrReg  <= '0;
      latWdataReg <= '0;
      iRdataReg   <= '0;
      dRdataReg   <= '0;
    end else begin
      stateReg <= stateNext;
      if (accept) begin
        lastDReg    <= d_gnt;
        latIsDReg   <= d_gnt;
        latWeReg    <= d_gnt && d_we;
        latAddrReg  <= d_gnt ? d_addr : i_addr;
        latWdataReg <= d_gnt ? d_wdata : '0;
      end
      if (i_done) iRdataReg <= mem_rdata;
      if (d_done) dRdataReg <= dRespData;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_gnt, i_done;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_done, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] seedVal(input int idx);
    if (idx == 4) return 32'h0050_0093;
    return idx * 32'h9E37_79B1 + 32'h0000_1234;
  endfunction

  // Synchronous memory: read-before-write, data one cycle after mem_en.
  logic [DW-1:0] tbMem [256];
  bit memInit = 1'b0;
  always @(posedge clk) begin
    if (!memInit) begin
      for (int k = 0; k < 256; k++) tbMem[k] <= seedVal(k);
      memInit <= 1'b1;
    end else if (mem_en) begin
      mem_rdata <= tbMem[mem_addr[9:2]];
      if (mem_we) tbMem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic checkVal(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding transfer, tracked by its age in cycles.
  logic [DW-1:0] refMem [256];
  bit            mActive, mIsD, mWe, mMis, mRdKnown, mLastD, mDKnown;
  int            mAge;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWdata, mExp, mIR, mDR;

  // Requester state: a pending request is held until its grant is seen.
  bit            iPend = 0, dPend = 0, dWe = 0, holdBoth = 0;
  logic [AW-1:0] iA = '0, dA = '0;
  logic [DW-1:0] dWd = '0;

  task automatic cycle(input bit rst);
    bit eI, eD, sawI, sawD, eMemEn, eIDone, eDDone;
    logic [DW-1:0] eIRd, eDRd;
    bit dRdCheck;
    reset   = rst;
    i_req   = iPend;
    i_addr  = iPend ? iA : '0;
    d_req   = dPend;
    d_we    = dPend && dWe;
    d_addr  = dPend ? dA : '0;
    d_wdata = dPend ? dWd : '0;
    #1;
    eI = 0; eD = 0;
    if (!rst && !mActive) begin
      if (iPend && dPend) eD = !mLastD;
      else eD = dPend;
      eI = iPend && !eD;
    end
    sawI = i_gnt; sawD = d_gnt;
    checkVal("i_gnt", i_gnt, eI);
    checkVal("d_gnt", d_gnt, eD);
    if (!rst) begin
      eMemEn = mActive && mAge == 1 && !mMis;
      checkVal("mem_en", mem_en, eMemEn);
      if (eMemEn) begin
        checkVal("mem_we", mem_we, mWe);
        checkVal("mem_addr", mem_addr, mAddr);
        if (mWe) checkVal("mem_wdata", mem_wdata, mWdata);
      end else if (mActive && mAge == 1) begin
        checkVal("mem_we_mis", mem_we, 0);
      end else begin
        checkVal("mem_we_idle", mem_we, 0);
        checkVal("mem_addr_idle", mem_addr, 0);
        checkVal("mem_wdata_idle", mem_wdata, 0);
      end
    end
    eIDone = !rst && mActive && mAge == 2 && !mIsD;
    eDDone = !rst && mActive && mAge == 2 && mIsD;
    checkVal("i_done", i_done, eIDone);
    checkVal("d_done", d_done, eDDone);
    checkVal("d_err", d_err, eDDone && mMis);
    if (!rst) begin
      eIRd = eIDone ? mExp : mIR;
      checkVal("i_rdata", i_rdata, eIRd);
      dRdCheck = eDDone ? mRdKnown : mDKnown;
      eDRd = eDDone ? mExp : mDR;
      if (dRdCheck) checkVal("d_rdata", d_rdata, eDRd);
    end
    @(posedge clk);
    if (rst) begin
      mActive = 0; mLastD = 0; mIR = '0; mDR = '0; mDKnown = 1; mAge = 0;
    end else if (mActive && mAge == 2) begin
      if (!mIsD) mIR = mExp;
      else begin mDR = mExp; mDKnown = mRdKnown; end
      mActive = 0;
    end else if (mActive) begin
      mAge = 2;
    end else if (eI || eD) begin
      mIsD    = eD;
      mAddr   = eD ? dA : iA;
      mWe     = eD && dWe;
      mWdata  = dWd;
      mMis    = eD && (dA[1:0] != 2'b00);
      mLastD  = eD;
      mActive = 1;
      mAge    = 1;
      if (mMis) begin
        mExp = '0; mRdKnown = 1;
      end else if (mWe) begin
        refMem[mAddr[9:2]] = dWd; mRdKnown = 0;
      end else begin
        mExp = refMem[mAddr[9:2]]; mRdKnown = 1;
      end
    end
    if (!rst && sawI && !holdBoth) iPend = 0;
    if (!rst && sawD && !holdBoth) dPend = 0;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cycle(0);
    checkVal("drain_idle", {30'd0, iPend, dPend}, 0);
  endtask

  initial begin
    logic [31:0] r;
    for (int k = 0; k < 256; k++) refMem[k] = seedVal(k);
    mActive = 0; mAge = 0; mLastD = 0; mIR = '0; mDR = '0; mDKnown = 1;
    mIsD = 0; mWe = 0; mMis = 0; mRdKnown = 1; mAddr = '0; mWdata = '0; mExp = '0;
    @(negedge clk);

    // Reset with both requests high: no grants while reset is asserted.
    iPend = 1; dPend = 1; iA = 32'h40; dA = 32'h44; dWe = 0;
    cycle(1); cycle(1);

    // Continuous contention: first grant D, then alternate.
    holdBoth = 1;
    for (int k = 0; k < 12; k++) cycle(0);
    holdBoth = 0;
    drain(8);

    // Fetch from 0x10 returning 0x00500093.
    iPend = 1; iA = 32'h10;
    drain(4);

    // Aligned store, then read it back.
    dPend = 1; dWe = 1; dA = 32'h20; dWd = 32'hDEAD_BEEF;
    drain(4);
    dPend = 1; dWe = 0; dA = 32'h20;
    drain(4);

    // Misaligned load.
    dPend = 1; dWe = 0; dA = 32'h22;
    drain(4);

    // Data request arriving during RESP of a fetch waits for IDLE.
    iPend = 1; iA = 32'h30;
    cycle(0); cycle(0);
    dPend = 1; dWe = 0; dA = 32'h34;
    drain(6);

    // Reset in ACCESS of a fetch aborts it; the next fetch is granted at once.
    iPend = 1; iA = 32'h50;
    cycle(0);
    cycle(1);
    iPend = 1; iA = 32'h54;
    drain(4);

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      if (!iPend && ($urandom % 3 == 0)) begin
        r = $urandom;
        iPend = 1; iA = {22'd0, r[9:0]};
      end
      if (!dPend && ($urandom % 3 == 0)) begin
        r = $urandom;
        dPend = 1; dWe = r[31];
        dA = {22'd0, r[9:2], (r[14:12] == 3'd0) ? r[1:0] : 2'b00};
        dWd = $urandom;
      end
      cycle(0);
    end
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
